// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Freeze/flush controller for a five-stage in-order pipeline.
//   - Memory-wait FSM (IDLE/WAIT) with a timeout counter. The timeout sets a
//     sticky mem_err.
//   - A data-hazard detector comparing the ID-stage sources against the
//     downstream producers.
//   - Branch flush and a saturating stall-cycle counter.
//
//   Configuration macro: FORWARDING_EN
//     defined   : only EXE-stage loads (exe_MEM_R_EN) cause a data hazard.
//     undefined : any EXE or MEM writeback (exe_WB_EN / mem_WB_EN) causes one.
//
//   Reset is synchronous and active-high. While rst is high, every freeze
//   output is 0 and both flush outputs are 1, so the pipeline fills with
//   bubbles.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic [3:0]       exe_Dest,
  input  logic             exe_WB_EN,
  input  logic             exe_MEM_R_EN,
  input  logic [3:0]       mem_Dest,
  input  logic             mem_WB_EN,
  input  logic             exe_B,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             id_exe_freeze,
  output logic             exe_mem_freeze,
  output logic             mem_wb_freeze,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             mem_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // The wait counter must be able to hold the value TIMEOUT itself.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              w_err_set;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_mem_freeze;
  logic              w_hazard;
  logic              w_any_freeze;

  // -------------------------------------------------------------------------
  // Data-hazard detection against the enabled producers.
  // -------------------------------------------------------------------------
`ifdef FORWARDING_EN
  // With forwarding, only a load in EXE cannot be bypassed in time.
  logic w_exe_load_hit1;
  logic w_exe_load_hit2;
  logic w_unused_fwd;

  assign w_exe_load_hit1 = exe_MEM_R_EN && (id_src1 == exe_Dest);
  assign w_exe_load_hit2 = exe_MEM_R_EN && (id_src2 == exe_Dest);
  assign w_hazard        = w_exe_load_hit1 || (id_two_src && w_exe_load_hit2);
  // Writeback flags and the MEM destination are irrelevant once bypassing exists.
  assign w_unused_fwd    = ^{exe_WB_EN, mem_Dest, mem_WB_EN};
`else
  // Without forwarding, any pending register write in EXE or MEM blocks ID.
  logic w_exe_hit1;
  logic w_exe_hit2;
  logic w_mem_hit1;
  logic w_mem_hit2;
  logic w_unused_fwd;

  assign w_exe_hit1   = exe_WB_EN && (id_src1 == exe_Dest);
  assign w_exe_hit2   = exe_WB_EN && (id_src2 == exe_Dest);
  assign w_mem_hit1   = mem_WB_EN && (id_src1 == mem_Dest);
  assign w_mem_hit2   = mem_WB_EN && (id_src2 == mem_Dest);
  assign w_hazard     = w_exe_hit1 || w_mem_hit1 ||
                        (id_two_src && (w_exe_hit2 || w_mem_hit2));
  // The load flag only matters when forwarding is built in.
  assign w_unused_fwd = exe_MEM_R_EN;
`endif

  // -------------------------------------------------------------------------
  // Memory FSM
  // -------------------------------------------------------------------------

  // The memory stage must hold while an access is outstanding. On the cycle
  // the counter reaches TIMEOUT the hold is released and the access is
  // abandoned.
  assign w_mem_freeze = ((r_state == S_IDLE) && mem_req && !sram_ready) ||
                        ((r_state == S_WAIT) && !sram_ready && (r_wait_cnt != TIMEOUT_V));

  // State register: holds the FSM state, the wait counter and the sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: every clocked state uses non-blocking (<=) assignments. Blocking
    // assignments here would let later statements see the updated values and
    // would race with other clocked blocks.
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= r_mem_err | w_err_set;
    end
  end

  // Next-state logic: IDLE to WAIT on a stalled request; WAIT ends on ready or timeout.
  always_comb begin
    // NOTE: every signal is given a default before the case statement. This
    // makes each path assign every output, so no latch is inferred.
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_err_set      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req && !sram_ready) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end
      end
      S_WAIT: begin
        if (sram_ready) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == TIMEOUT_V) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = '0;
          w_err_set      = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Freeze / flush outputs
  // -------------------------------------------------------------------------

  // Priority order: reset, then memory freeze, then branch flush, then data-hazard stall.
  always_comb begin
    pc_freeze      = 1'b0;
    if_id_freeze   = 1'b0;
    id_exe_freeze  = 1'b0;
    exe_mem_freeze = 1'b0;
    mem_wb_freeze  = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_flush   = 1'b0;
    if (rst) begin
      if_id_flush    = 1'b1;
      id_exe_flush   = 1'b1;
    end else if (w_mem_freeze) begin
      // The whole pipe holds. A branch sitting in EXE stays there and is
      // acted on in the first cycle after the memory stall ends.
      pc_freeze      = 1'b1;
      if_id_freeze   = 1'b1;
      id_exe_freeze  = 1'b1;
      exe_mem_freeze = 1'b1;
      mem_wb_freeze  = 1'b1;
    end else if (exe_B) begin
      // A taken branch discards the wrong-path instructions in IF/ID and
      // ID/EXE. A hazard on those instructions no longer matters.
      if_id_flush    = 1'b1;
      id_exe_flush   = 1'b1;
    end else if (w_hazard) begin
      // Hold fetch and decode, and send a bubble into EXE.
      pc_freeze      = 1'b1;
      if_id_freeze   = 1'b1;
      id_exe_flush   = 1'b1;
    end
  end

  assign w_any_freeze = pc_freeze | if_id_freeze | id_exe_freeze |
                        exe_mem_freeze | mem_wb_freeze;

  // Stall counter: counts every cycle in which any stage is held, and saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_any_freeze && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign mem_busy  = (r_state == S_WAIT);
  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl.
//   - Two instances share the same stimulus: the default build and a 4-bit
//     stall counter build, so saturation can be observed.
//   - Expected values come from a behavioural model. The model keeps a
//     pending-register mask, a wait flag, an integer wait count and an
//     integer stall count.
//   - Inputs change 1 ns after the rising edge; outputs are sampled on the
//     falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_Dest, mem_Dest;
  logic       id_two_src, exe_WB_EN, exe_MEM_R_EN, mem_WB_EN;
  logic       exe_B, mem_req, sram_ready;

  logic        pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze, mem_wb_freeze;
  logic        if_id_flush, id_exe_flush, mem_busy, mem_err;
  logic [15:0] stall_cnt;

  logic        s_pc_freeze, s_if_id_freeze, s_id_exe_freeze, s_exe_mem_freeze, s_mem_wb_freeze;
  logic        s_if_id_flush, s_id_exe_flush, s_mem_busy, s_mem_err;
  logic [3:0]  s_stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_Dest(exe_Dest), .exe_WB_EN(exe_WB_EN), .exe_MEM_R_EN(exe_MEM_R_EN),
    .mem_Dest(mem_Dest), .mem_WB_EN(mem_WB_EN), .exe_B(exe_B), .mem_req(mem_req),
    .sram_ready(sram_ready), .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
    .id_exe_freeze(id_exe_freeze), .exe_mem_freeze(exe_mem_freeze),
    .mem_wb_freeze(mem_wb_freeze), .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .mem_busy(mem_busy), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_Dest(exe_Dest), .exe_WB_EN(exe_WB_EN), .exe_MEM_R_EN(exe_MEM_R_EN),
    .mem_Dest(mem_Dest), .mem_WB_EN(mem_WB_EN), .exe_B(exe_B), .mem_req(mem_req),
    .sram_ready(sram_ready), .pc_freeze(s_pc_freeze), .if_id_freeze(s_if_id_freeze),
    .id_exe_freeze(s_id_exe_freeze), .exe_mem_freeze(s_exe_mem_freeze),
    .mem_wb_freeze(s_mem_wb_freeze), .if_id_flush(s_if_id_flush), .id_exe_flush(s_id_exe_flush),
    .mem_busy(s_mem_busy), .mem_err(s_mem_err), .stall_cnt(s_stall_cnt)
  );

  // Observed control vector: {pc, if_id, id_exe, exe_mem, mem_wb freezes, if_id_flush, id_exe_flush}.
  wire [6:0]  obs_ctl   = {pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze,
                           mem_wb_freeze, if_id_flush, id_exe_flush};
  wire [6:0]  s_obs_ctl = {s_pc_freeze, s_if_id_freeze, s_id_exe_freeze, s_exe_mem_freeze,
                           s_mem_wb_freeze, s_if_id_flush, s_id_exe_flush};
  // Observed status: {busy, err, 16-bit stall count, 4-bit saturating stall count}.
  wire [21:0] obs_st    = {mem_busy, mem_err, stall_cnt, s_stall_cnt};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model state.
  bit m_in_wait;
  int m_wait_cnt;
  bit m_err;
  int m_stalls;

  // Expected freeze/flush vector for the current inputs and model state.
  function automatic logic [6:0] exp_ctl();
    logic [15:0] pending;
    logic        hazard;
    logic        mfrz;
    pending = '0;
`ifdef FORWARDING_EN
    if (exe_MEM_R_EN) pending[exe_Dest] = 1'b1;
`else
    if (exe_WB_EN) pending[exe_Dest] = 1'b1;
    if (mem_WB_EN) pending[mem_Dest] = 1'b1;
`endif
    hazard = pending[id_src1] || (id_two_src && pending[id_src2]);
    mfrz   = m_in_wait ? (!sram_ready && m_wait_cnt != TIMEOUT) : (mem_req && !sram_ready);
    if (rst)   return 7'b00000_11;
    if (mfrz)  return 7'b11111_00;
    if (exe_B) return 7'b00000_11;
    if (hazard) return 7'b11000_01;
    return 7'b00000_00;
  endfunction

  // Expected status vector from the model.
  function automatic logic [21:0] exp_st();
    logic [3:0] sat;
    sat = (m_stalls > 15) ? 4'd15 : 4'(m_stalls);
    return {m_in_wait, m_err, 16'(m_stalls), sat};
  endfunction

  // Advance one clock and update the model with the inputs present at that edge.
  task automatic tick();
    logic [6:0] ctl;
    ctl = exp_ctl();
    @(posedge clk);
    if (rst) begin
      m_in_wait = 0; m_wait_cnt = 0; m_err = 0; m_stalls = 0;
    end else begin
      if (|ctl[6:2]) m_stalls++;
      if (!m_in_wait) begin
        if (mem_req && !sram_ready) begin m_in_wait = 1; m_wait_cnt = 1; end
      end else if (sram_ready) begin
        m_in_wait = 0; m_wait_cnt = 0;
      end else if (m_wait_cnt == TIMEOUT) begin
        m_in_wait = 0; m_wait_cnt = 0; m_err = 1;
      end else begin
        m_wait_cnt++;
      end
    end
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 0; exe_Dest = 4'd0;
    exe_WB_EN = 0; exe_MEM_R_EN = 0; mem_Dest = 4'd0; mem_WB_EN = 0;
    exe_B = 0; mem_req = 0; sram_ready = 0;
  endtask

  task automatic rand_regs();
    id_src1    = 4'($urandom_range(0, 3));
    id_src2    = 4'($urandom_range(0, 3));
    id_two_src = 1'($urandom);
    exe_Dest   = 4'($urandom_range(0, 3));
    mem_Dest   = 4'($urandom_range(0, 3));
    exe_WB_EN    = 1'($urandom);
    exe_MEM_R_EN = 1'($urandom);
    mem_WB_EN    = 1'($urandom);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      rand_regs();
      exe_B = 1'($urandom); mem_req = 1'($urandom); sram_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs_ctl !== 7'b00000_11)
        $display("FAIL reset_ctl cyc=%0d got=%b exp=%b", cyc, obs_ctl, 7'b00000_11);
      if (obs_ctl !== 7'b00000_11) failures++;
      tick();
    end
    rst = 0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (obs_st !== 22'd0) begin
      failures++;
      $display("FAIL reset_status cyc=%0d got=%h exp=%h", cyc, obs_st, 22'd0);
    end
  endtask

  task automatic test_hazard();
    logic [6:0] want;
    do_reset();
    id_src1 = 4'd3; exe_Dest = 4'd3; exe_WB_EN = 1; exe_MEM_R_EN = 0; mem_Dest = 4'd5;
`ifdef FORWARDING_EN
    want = 7'b00000_00;
`else
    want = 7'b11000_01;
`endif
    @(negedge clk);
    checks++;
    if (obs_ctl !== want) begin
      failures++;
      $display("FAIL hazard_directed cyc=%0d got=%b exp=%b", cyc, obs_ctl, want);
    end
    tick();
    for (int i = 0; i < 60; i++) begin
      rand_regs();
      exe_B = ($urandom_range(0, 3) == 0); mem_req = 0; sram_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs_ctl !== exp_ctl()) begin
        failures++;
        $display("FAIL hazard_rand cyc=%0d got=%b exp=%b", cyc, obs_ctl, exp_ctl());
      end
      checks++;
      if (obs_st !== exp_st()) begin
        failures++;
        $display("FAIL hazard_status cyc=%0d got=%h exp=%h", cyc, obs_st, exp_st());
      end
      tick();
    end
  endtask

  task automatic test_branch();
    do_reset();
    id_src1 = 4'd7; exe_Dest = 4'd7; exe_WB_EN = 1; exe_MEM_R_EN = 1; exe_B = 1;
    @(negedge clk);
    checks++;
    if (obs_ctl !== 7'b00000_11) begin
      failures++;
      $display("FAIL branch_over_hazard cyc=%0d got=%b exp=%b", cyc, obs_ctl, 7'b00000_11);
    end
    tick();
  endtask

  task automatic test_mem_stall();
    do_reset();
    mem_req = 1; sram_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) sram_ready = 1;
      @(negedge clk);
      checks++;
      if (obs_ctl[6:2] !== ((i <= 4) ? 5'b11111 : 5'b00000) || obs_ctl[1:0] !== 2'b00) begin
        failures++;
        $display("FAIL mem_stall_ctl cycle=%0d got=%b", i, obs_ctl);
      end
      checks++;
      if (mem_busy !== (i >= 2)) begin
        failures++;
        $display("FAIL mem_stall_busy cycle=%0d got=%b exp=%b", i, mem_busy, (i >= 2));
      end
      tick();
    end
    mem_req = 0; sram_ready = 0;
    @(negedge clk);
    checks++;
    if (mem_busy !== 1'b0 || stall_cnt !== 16'd4) begin
      failures++;
      $display("FAIL mem_stall_end busy=%b stall_cnt=%0d exp busy=0 stall_cnt=4", mem_busy, stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1; sram_ready = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (pc_freeze !== (i <= TIMEOUT) || mem_err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_window cycle=%0d freeze=%b err=%b exp freeze=%b err=0",
                 i, pc_freeze, mem_err, (i <= TIMEOUT));
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      sram_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (mem_err !== 1'b1 || obs_st !== exp_st()) begin
        failures++;
        $display("FAIL timeout_sticky cyc=%0d got=%h exp=%h", cyc, obs_st, exp_st());
      end
      tick();
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear got=%b exp=0", mem_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_req = 1; sram_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1;
    @(negedge clk);
    checks++;
    if (obs_ctl !== 7'b00000_11 || mem_busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_wait_during ctl=%b busy=%b exp ctl=0000011 busy=1", obs_ctl, mem_busy);
    end
    tick();
    rst = 0; mem_req = 0;
    @(negedge clk);
    checks++;
    if (mem_busy !== 1'b0 || mem_err !== 1'b0 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_mid_wait_after busy=%b err=%b stall=%0d exp 0 0 0", mem_busy, mem_err, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    id_src1 = 4'd9; exe_Dest = 4'd9; exe_WB_EN = 1; exe_MEM_R_EN = 1;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    checks++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
      failures++;
      $display("FAIL saturation sat=%0d full=%0d exp sat=15 full=20", s_stall_cnt, stall_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_regs();
      rst        = ($urandom_range(0, 49) == 0);
      exe_B      = ($urandom_range(0, 3) == 0);
      mem_req    = 1'($urandom);
      sram_ready = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      checks++;
      if (obs_ctl !== exp_ctl() || s_obs_ctl !== exp_ctl()) begin
        failures++;
        $display("FAIL random_ctl cyc=%0d got=%b/%b exp=%b", cyc, obs_ctl, s_obs_ctl, exp_ctl());
      end
      checks++;
      if (obs_st !== exp_st() || s_mem_busy !== m_in_wait || s_mem_err !== m_err) begin
        failures++;
        $display("FAIL random_status cyc=%0d got=%h exp=%h", cyc, obs_st, exp_st());
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    m_in_wait = 0; m_wait_cnt = 0; m_err = 0; m_stalls = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_hazard();
    test_branch();
    test_mem_stall();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
